// File: rtl/rd_resp_mux_pkg.sv
// Shared types and constants for the read-response return path.
// A sel_tag_t follows each read from issue to response, so the data can be steered back.
package rd_resp_mux_pkg;

    localparam int unsigned MAX_SLV   = 16;
    localparam int unsigned IDX_W     = $clog2(MAX_SLV);
    localparam int unsigned ERR_CNT_W = 16;

    // Select information captured when a read is issued.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             hit;
        logic             multi;
    } sel_tag_t;

endpackage

// File: rtl/rd_sel_pipe.sv
// Delay line for sel_tag_t that matches the slave read latency.
// With DEPTH=0 the line is a plain wire, which gives the same-cycle path used with async memories.
module rd_sel_pipe
    import rd_resp_mux_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  sel_tag_t tag_i,
    output sel_tag_t tag_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign tag_o = tag_i;
            // The clock and reset have no purpose without storage.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
        end else begin : g_pipe
            sel_tag_t stage_q [DEPTH];

            // Shift the tags forward one stage per cycle; reset drops every read still in flight.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= tag_i;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign tag_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/rd_resp_mux.sv
// Read-data return path from NUM_SLV memory-mapped slaves to the CPU load port.
// Slave 0 has the highest priority when several chip selects are active.
// Optional feature: define DATA_MUX_ERR_EN to enable the saturating error counter on err_cnt.
module rd_resp_mux
    import rd_resp_mux_pkg::*;
#(
    parameter int unsigned NUM_SLV   = 3,
    parameter int unsigned DW        = 32,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [DW-1:0] DFLT_DATA = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic [NUM_SLV-1:0]    cs_n,
    input  logic [NUM_SLV*DW-1:0] rd_data_slv,
    output logic [DW-1:0]         rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    input  logic                  err_clr
);

    sel_tag_t      tag_d;
    sel_tag_t      tag_q;
    logic [DW-1:0] resp_data;
    logic [DW-1:0] hold_q;
    logic          resp_err;

    // Fixed-priority encoder over the active-low chip selects; a read issued during reset is dropped.
    always_comb begin
        tag_d       = '0;
        tag_d.vld   = rd_req & ~reset;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (!cs_n[i]) begin
                if (tag_d.hit) begin
                    tag_d.multi = 1'b1;
                end else begin
                    tag_d.hit = 1'b1;
                    tag_d.idx = IDX_W'(i);
                end
            end
        end
    end

    rd_sel_pipe #(
        .DEPTH (RD_LAT)
    ) u_pipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (tag_d),
        .tag_o (tag_q)
    );

    // Steer the selected slave's data; an unmapped read returns the default pattern.
    always_comb begin
        resp_data = DFLT_DATA;
        if (tag_q.hit) begin
            for (int i = 0; i < int'(NUM_SLV); i++) begin
                if (tag_q.idx == IDX_W'(i)) begin
                    resp_data = rd_data_slv[i*DW +: DW];
                end
            end
        end
        resp_err = ~tag_q.hit | tag_q.multi;
    end

    // Keep the last response visible on rd_data between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= DFLT_DATA;
        end else if (tag_q.vld) begin
            hold_q <= resp_data;
        end
    end

    assign rd_valid = tag_q.vld;
    assign rd_data  = tag_q.vld ? resp_data : hold_q;
    assign rd_err   = tag_q.vld & resp_err;

`ifdef DATA_MUX_ERR_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 err_sticky_q;
    logic                 err_evt;

    assign err_evt = rd_valid & rd_err;

    // Count error responses, saturating; a clear coinciding with an error restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else if (err_clr) begin
            err_cnt_q    <= err_evt ? ERR_CNT_W'(1) : '0;
            err_sticky_q <= err_evt;
        end else if (err_evt) begin
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            err_sticky_q <= 1'b1;
        end
    end

    // The sticky flag and a non-zero count always agree, so the count alone is exported.
    logic unused_sticky;
    assign unused_sticky = err_sticky_q;
    assign err_cnt       = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule
